fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Holds the program counter and runs the instruction-fetch handshake.
- Consumes the 32-bit next-PC value produced by the 4:1 PC-source mux and feeds PC_PLUS4 back to the mux's D0 input.
- Presents one fetched instruction at a time to decode with a valid/ready handshake.
- Supports redirect/flush, including discarding an in-flight memory response.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset.

Ports:
CLK  in  1  system clock; single clock domain; all state updates on rising edge.
RST_N  in  1  reset, asynchronous assert, active-low.
NEXT_PC  in  32  next PC from the PC-source mux.
PC  out  32  current fetch PC (registered).
PC_PLUS4  out  32  PC + 4, combinational, wraps modulo 2^32.
FLUSH  in  1  redirect: load NEXT_PC and discard the current fetch or held instruction.
IMEM_REQ  out  1  fetch request, combinational from state.
IMEM_ADDR  out  32  equals PC.
IMEM_GNT  in  1  request accepted this cycle.
IMEM_RVALID  in  1  response valid; at most one response per granted request.
IMEM_RDATA  in  32  instruction word.
IR_VALID  out  1  IR/IR_PC valid to decode.
IR_READY  in  1  decode accepts.
IR  out  32  held instruction.
IR_PC  out  32  PC of IR.
MISALIGN  out  1  misaligned-target flag; tied 0 when the feature is off.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, PC=RESET_VECTOR, IR=0, IR_PC=0, IR_VALID=0, MISALIGN=0, IMEM_REQ=0. Reset mid-fetch abandons the fetch; responses arriving in IDLE are ignored.
- States:
  - IDLE: go to REQ on the next cycle.
  - REQ: IMEM_REQ=1.
    - GNT & !FLUSH -> WAIT.
    - FLUSH & !GNT -> load PC; stay in REQ.
    - FLUSH & GNT -> load PC; go to DRAIN.
  - WAIT: IMEM_REQ=0.
    - RVALID & !FLUSH -> IR<=RDATA, IR_PC<=PC, IR_VALID<=1; go to HOLD.
    - RVALID & FLUSH -> drop the data, load PC; go to REQ.
    - !RVALID & FLUSH -> load PC; go to DRAIN.
  - DRAIN: IMEM_REQ=0; swallow exactly one response. RVALID -> REQ. FLUSH in DRAIN loads PC again and stays in DRAIN.
  - HOLD: IR_VALID=1; IR/IR_PC stable.
    - FLUSH (priority over IR_READY) -> IR_VALID<=0, load PC; go to REQ.
    - IR_READY -> IR_VALID<=0, load PC; go to REQ.
- "Load PC" means PC<=NEXT_PC, sampled in the same cycle as the triggering event.
- Latency:
  - Best case REQ->GNT->RVALID gives IR_VALID 1 cycle after RVALID.
  - Issue rate is one fetch per handshake; no overlap.
  - After an accept, the next IMEM_REQ is asserted the following cycle.
- Alignment without the feature: loaded PC[1:0] forced to 2'b00.
- PC_PLUS4 at 32'hFFFF_FFFC is 32'h0000_0000.
- IMEM_RVALID outside WAIT/DRAIN is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- Enabled:
  - A PC load with NEXT_PC[1:0]!=0 loads PC unmodified, sets MISALIGN=1, and enters state FAULT.
  - FAULT: IMEM_REQ=0, IR_VALID=0.
  - Only FLUSH with aligned NEXT_PC leaves FAULT: MISALIGN<=0, go to REQ.
  - A misaligned FLUSH in FAULT reloads PC and stays in FAULT.
- Disabled: low bits are forced to 0, the FAULT state does not exist, and MISALIGN is constant 0.

Decomposition:
- Package carp_fetch_pkg:
  - fetch_state_t enum (IDLE, REQ, WAIT, DRAIN, HOLD, FAULT).
  - INSN_W=32.
  - PC_STEP=32'd4.
- No sub-module; the PC-source mux stays external and is instantiated by the parent with D0=PC_PLUS4.

Test Plan:
1. Reset release, RESET_VECTOR=32'h100, GNT=1 immediately, RVALID 2 cycles later with 32'h00500093 -> IMEM_ADDR=32'h100; IR=32'h00500093, IR_PC=32'h100, IR_VALID=1 held while IR_READY=0 for 5 cycles.
2. HOLD, IR_READY=1, NEXT_PC=32'h104 -> IR_VALID drops next cycle; PC=32'h104; IMEM_REQ=1 one cycle later.
3. FLUSH in WAIT with NEXT_PC=32'h200, stale RVALID 3 cycles later -> stale data never appears on IR; next request has IMEM_ADDR=32'h200.
4. HOLD with FLUSH=1 and IR_READY=1 in the same cycle, NEXT_PC=32'h300 -> IR_VALID=0 and PC=32'h300; flush priority confirmed.
5. PC=32'hFFFF_FFFC -> PC_PLUS4=32'h0; NEXT_PC=32'h0000_0102 loads 32'h100 (macro off).
6. FETCH_MISALIGN_EN defined:
   - NEXT_PC=32'h102 on accept -> MISALIGN=1, IMEM_REQ=0.
   - FLUSH with NEXT_PC=32'h100 -> MISALIGN=0, request issued to 32'h100.
   - RST_N pulsed low mid-WAIT -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/carp_fetch_pkg.sv
// Shared types and constants for the fetch PC unit.
//   fetch_state_t : fetch handshake states
//   INSN_W        : instruction / PC width
//   PC_STEP       : sequential PC increment
package carp_fetch_pkg;

    localparam int          INSN_W  = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4,
        FAULT = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch handshake.
//
// Holds the PC, issues one instruction-memory fetch at a time and presents
// the returned word to decode with a valid/ready handshake. Redirects (FLUSH)
// load NEXT_PC from the external PC-source mux; a response still owed by
// memory after a redirect is swallowed in DRAIN.
//
// Optional feature macro: FETCH_MISALIGN_EN
//   defined   : misaligned PC loads are kept as-is, raise MISALIGN and park in FAULT
//   undefined : loaded PC[1:0] forced to 0, MISALIGN tied 0
//
// Ports:
//   CLK, RST_N           clock, async active-low reset
//   NEXT_PC              next PC from PC-source mux
//   PC, PC_PLUS4         current PC, PC+4 (to mux D0)
//   FLUSH                redirect
//   IMEM_REQ/ADDR/GNT    fetch request channel
//   IMEM_RVALID/RDATA    fetch response channel
//   IR_VALID/READY       decode handshake
//   IR, IR_PC            held instruction and its PC
//   MISALIGN             misaligned-target flag
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | out of reset, request starts next cycle
// REQ   | IMEM_REQ high, waiting for grant
// WAIT  | granted, waiting for the response
// DRAIN | response owed to a redirected fetch, discard it
// HOLD  | instruction held for decode
// FAULT | misaligned PC loaded, only an aligned FLUSH leaves
module fetch_pc_unit
    import carp_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       NEXT_PC,
    output logic [31:0]       PC,
    output logic [31:0]       PC_PLUS4,
    input  logic              FLUSH,
    output logic              IMEM_REQ,
    output logic [31:0]       IMEM_ADDR,
    input  logic              IMEM_GNT,
    input  logic              IMEM_RVALID,
    input  logic [INSN_W-1:0] IMEM_RDATA,
    output logic              IR_VALID,
    input  logic              IR_READY,
    output logic [INSN_W-1:0] IR,
    output logic [31:0]       IR_PC,
    output logic              MISALIGN
);

    fetch_state_t      state_q;
    logic [31:0]       pc_q;
    logic [INSN_W-1:0] ir_q;
    logic [31:0]       ir_pc_q;
    logic              ir_valid_q;
    logic [31:0]       load_pc;
    logic              load_en;
    logic              load_bad;

`ifdef FETCH_MISALIGN_EN
    logic misalign_q;
    assign load_pc  = NEXT_PC;
    assign load_bad = |NEXT_PC[1:0];
    assign MISALIGN = misalign_q;
`else
    logic [1:0] unused_next_pc_lsb;
    assign unused_next_pc_lsb = NEXT_PC[1:0];
    assign load_pc  = {NEXT_PC[31:2], 2'b00};
    assign load_bad = 1'b0;
    assign MISALIGN = 1'b0;
`endif

    // Every PC load shares one path; only the trigger differs per state.
    assign load_en = (FLUSH && (state_q != IDLE)) ||
                     ((state_q == HOLD) && IR_READY);

    // A misaligned load diverts whatever the intended next state was.
    function automatic fetch_state_t load_target(input fetch_state_t dest,
                                                 input logic         bad);
        return bad ? FAULT : dest;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            if (load_en) begin
                pc_q <= load_pc;
`ifdef FETCH_MISALIGN_EN
                misalign_q <= load_bad;
`endif
            end
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (FLUSH) begin
                        // A grant in the flush cycle still owes a response.
                        state_q <= load_target(IMEM_GNT ? DRAIN : REQ, load_bad);
                    end else if (IMEM_GNT) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (FLUSH) begin
                        state_q <= load_target(IMEM_RVALID ? REQ : DRAIN, load_bad);
                    end else if (IMEM_RVALID) begin
                        ir_q       <= IMEM_RDATA;
                        ir_pc_q    <= pc_q;
                        ir_valid_q <= 1'b1;
                        state_q    <= HOLD;
                    end
                end
                DRAIN: begin
                    if (FLUSH) begin
                        state_q <= load_target(IMEM_RVALID ? REQ : DRAIN, load_bad);
                    end else if (IMEM_RVALID) begin
                        state_q <= REQ;
                    end
                end
                HOLD: begin
                    if (FLUSH || IR_READY) begin
                        ir_valid_q <= 1'b0;
                        state_q    <= load_target(REQ, load_bad);
                    end
                end
`ifdef FETCH_MISALIGN_EN
                FAULT: begin
                    if (FLUSH) begin
                        state_q <= load_target(REQ, load_bad);
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PC        = pc_q;
    assign PC_PLUS4  = pc_q + PC_STEP;
    assign IMEM_REQ  = (state_q == REQ);
    assign IMEM_ADDR = pc_q;
    assign IR        = ir_q;
    assign IR_PC     = ir_pc_q;
    assign IR_VALID  = ir_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] NEXT_PC;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        FLUSH;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        IR_VALID;
    logic        IR_READY;
    logic [31:0] IR;
    logic [31:0] IR_PC;
    logic        MISALIGN;

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit #(.RESET_VECTOR(32'h0000_0100)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .NEXT_PC     (NEXT_PC),
        .PC          (PC),
        .PC_PLUS4    (PC_PLUS4),
        .FLUSH       (FLUSH),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .IR_VALID    (IR_VALID),
        .IR_READY    (IR_READY),
        .IR          (IR),
        .IR_PC       (IR_PC),
        .MISALIGN    (MISALIGN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},       PC,               32'h100);
        check({tag, "_ir"},       IR,               32'h0);
        check({tag, "_ir_pc"},    IR_PC,            32'h0);
        check({tag, "_ir_valid"}, {31'd0, IR_VALID}, 32'd0);
        check({tag, "_req"},      {31'd0, IMEM_REQ}, 32'd0);
        check({tag, "_misalign"}, {31'd0, MISALIGN}, 32'd0);
    endtask

    initial begin
        RST_N       = 1'b0;
        NEXT_PC     = 32'h0;
        FLUSH       = 1'b0;
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'h0;
        IR_READY    = 1'b0;
        step(2);
        check_reset_outputs("rst");

        // 1: basic fetch with grant immediately, response 2 cycles after grant
        RST_N    = 1'b1;
        IMEM_GNT = 1'b1;
        step();                                   // IDLE -> REQ
        check("t1_req",  {31'd0, IMEM_REQ}, 32'd1);
        check("t1_addr", IMEM_ADDR, 32'h100);
        step();                                   // REQ -> WAIT
        IMEM_GNT = 1'b0;
        check("t1_wait_req", {31'd0, IMEM_REQ}, 32'd0);
        step();
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'h0050_0093;
        step();                                   // WAIT -> HOLD
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'h0;
        check("t1_ir",    IR,    32'h0050_0093);
        check("t1_ir_pc", IR_PC, 32'h100);
        for (int i = 0; i < 5; i++) begin
            check("t1_hold_valid", {31'd0, IR_VALID}, 32'd1);
            check("t1_hold_ir",    IR, 32'h0050_0093);
            step();
        end

        // 2: accept in HOLD
        NEXT_PC  = 32'h104;
        IR_READY = 1'b1;
        step();
        IR_READY = 1'b0;
        check("t2_valid", {31'd0, IR_VALID}, 32'd0);
        check("t2_pc",    PC, 32'h104);
        check("t2_req",   {31'd0, IMEM_REQ}, 32'd1);
        check("t2_addr",  IMEM_ADDR, 32'h104);

        // 3: flush in WAIT, stale response swallowed
        IMEM_GNT = 1'b1;
        step();                                   // REQ -> WAIT
        IMEM_GNT = 1'b0;
        NEXT_PC  = 32'h200;
        FLUSH    = 1'b1;
        step();                                   // WAIT -> DRAIN
        FLUSH = 1'b0;
        check("t3_pc",        PC, 32'h200);
        check("t3_drain_req", {31'd0, IMEM_REQ}, 32'd0);
        step(2);
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'hDEAD_BEEF;
        step();                                   // DRAIN -> REQ
        IMEM_RVALID = 1'b0;
        check("t3_valid", {31'd0, IR_VALID}, 32'd0);
        check("t3_ir",    IR, 32'h0050_0093);
        check("t3_req",   {31'd0, IMEM_REQ}, 32'd1);
        check("t3_addr",  IMEM_ADDR, 32'h200);
        IMEM_GNT = 1'b1;
        step();
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'h00A0_0113;
        step();
        IMEM_RVALID = 1'b0;
        check("t3_new_ir",    IR,    32'h00A0_0113);
        check("t3_new_ir_pc", IR_PC, 32'h200);
        check("t3_new_valid", {31'd0, IR_VALID}, 32'd1);

        // 4: FLUSH and IR_READY together in HOLD
        NEXT_PC  = 32'h300;
        FLUSH    = 1'b1;
        IR_READY = 1'b1;
        step();
        FLUSH    = 1'b0;
        IR_READY = 1'b0;
        check("t4_valid", {31'd0, IR_VALID}, 32'd0);
        check("t4_pc",    PC, 32'h300);
        check("t4_req",   {31'd0, IMEM_REQ}, 32'd1);

        // 5: wrap of PC_PLUS4, then flush in REQ without grant stays in REQ
        NEXT_PC = 32'hFFFF_FFFC;
        FLUSH   = 1'b1;
        step();
        FLUSH = 1'b0;
        check("t5_pc_top",  PC, 32'hFFFF_FFFC);
        check("t5_plus4",   PC_PLUS4, 32'h0);
        check("t5_req",     {31'd0, IMEM_REQ}, 32'd1);
`ifndef FETCH_MISALIGN_EN
        NEXT_PC = 32'h0000_0102;
        FLUSH   = 1'b1;
        step();
        FLUSH = 1'b0;
        check("t5_align_pc", PC, 32'h100);
        check("t5_misalign", {31'd0, MISALIGN}, 32'd0);
        check("t5_req2",     {31'd0, IMEM_REQ}, 32'd1);
`else
        // 6: misaligned target on accept
        IMEM_GNT = 1'b1;
        step();
        IMEM_GNT    = 1'b0;
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'h1111_2222;
        step();
        IMEM_RVALID = 1'b0;
        check("t6_hold_valid", {31'd0, IR_VALID}, 32'd1);
        NEXT_PC  = 32'h102;
        IR_READY = 1'b1;
        step();
        IR_READY = 1'b0;
        check("t6_misalign", {31'd0, MISALIGN}, 32'd1);
        check("t6_req",      {31'd0, IMEM_REQ}, 32'd0);
        check("t6_valid",    {31'd0, IR_VALID}, 32'd0);
        check("t6_pc",       PC, 32'h102);
        NEXT_PC = 32'h106;
        FLUSH   = 1'b1;
        step();
        FLUSH = 1'b0;
        check("t6_re_misalign", {31'd0, MISALIGN}, 32'd1);
        check("t6_re_pc",       PC, 32'h106);
        check("t6_re_req",      {31'd0, IMEM_REQ}, 32'd0);
        NEXT_PC = 32'h100;
        FLUSH   = 1'b1;
        step();
        FLUSH = 1'b0;
        check("t6_clr_misalign", {31'd0, MISALIGN}, 32'd0);
        check("t6_clr_req",      {31'd0, IMEM_REQ}, 32'd1);
        check("t6_clr_addr",     IMEM_ADDR, 32'h100);
`endif

        // Async reset mid-WAIT: IR and IR_PC are nonzero beforehand
        NEXT_PC  = 32'h0000_0400;
        IMEM_GNT = 1'b1;
        step();                                   // REQ -> WAIT
        IMEM_GNT = 1'b0;
        check("ar_wait_req", {31'd0, IMEM_REQ}, 32'd0);
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("ar");
        step();
        RST_N       = 1'b1;
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'hBAD0_BAD0;
        step();                                   // IDLE ignores RVALID
        check("ar_idle_valid", {31'd0, IR_VALID}, 32'd0);
        check("ar_idle_req",   {31'd0, IMEM_REQ}, 32'd1);
        step();                                   // REQ ignores RVALID
        IMEM_RVALID = 1'b0;
        check("ar_req_valid", {31'd0, IR_VALID}, 32'd0);
        check("ar_req_ir",    IR, 32'h0);
        check("ar_req_req",   {31'd0, IMEM_REQ}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
